// File: rtl/nios_debug_cmd_bridge.sv
// nios_debug_cmd_bridge
// System-clock side of the Nios II debug slave. Brings the virtual-JTAG
// update-IR / update-DR levels into clk, queues every completed DR scan
// together with its instruction, and hands commands to the CPU debug logic
// through a valid/ready handshake. Each popped command produces a one-hot
// take-action or take-no-action pulse, and its data is held on jdo until
// the next pop.

module nios_debug_cmd_bridge #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACTION_BIT  = 35,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NCH        = 2 ** IR_W,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_uir,
    input  logic            vs_udr,
    input  logic [IR_W-1:0] ir_in,
    input  logic [DR_W-1:0] sr,
    input  logic            cmd_ready,
    input  logic            ovf_clr,
    output logic            cmd_valid,
    output logic [IR_W-1:0] cmd_ir,
    output logic [DR_W-1:0] cmd_data,
    output logic [DR_W-1:0] jdo,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action,
    output logic [CW-1:0]   cmd_count,
    output logic            ovf
);

    // Pointer and FIFO entry widths; an entry is {ir, data}.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = IR_W + DR_W;

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] uirSync_q;
    logic [SYNC_STAGES-1:0] udrSync_q;
    logic                   uirHist_q;
    logic                   udrHist_q;
    logic                   uirStrobe;
    logic                   udrStrobe;

    // Resynchronise both update levels; chains preset to 1 so a line that
    // is already high when reset releases is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uirSync_q <= '1;
            udrSync_q <= '1;
            uirHist_q <= 1'b1;
            udrHist_q <= 1'b1;
        end else begin
            uirSync_q <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
            udrSync_q <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
            uirHist_q <= uirSync_q[SYNC_STAGES-1];
            udrHist_q <= udrSync_q[SYNC_STAGES-1];
        end
    end

    // Rising-edge detection on the synchronised levels.
    always_comb begin
        uirStrobe = uirSync_q[SYNC_STAGES-1] & ~uirHist_q;
        udrStrobe = udrSync_q[SYNC_STAGES-1] & ~udrHist_q;
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_W-1:0] irReg_q;
    logic [IR_W-1:0] irReg_d;
    logic [IR_W-1:0] irSel;

    // Capture the instruction on an IR strobe; a DR strobe in the same
    // cycle must see the new instruction, so it bypasses the register.
    always_comb begin
        irReg_d = irReg_q;
        irSel   = irReg_q;
        if (uirStrobe) begin
            irReg_d = ir_in;
            irSel   = ir_in;
        end
    end

    // Instruction register state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irReg_q <= '0;
        end else begin
            irReg_q <= irReg_d;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] wrPtr_d;
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] rdPtr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          fifoFull;
    logic          popReq;
    logic          pushAccept;
    logic          pushDrop;
    logic [EW-1:0] headEntry;

    // Handshake qualification: a push into a full FIFO is only taken when
    // a pop frees the head slot in the same cycle, otherwise it is dropped.
    always_comb begin
        fifoFull   = (count_q == CW'(FIFO_DEPTH));
        popReq     = cmd_valid & cmd_ready;
        pushAccept = udrStrobe & (~fifoFull | popReq);
        pushDrop   = udrStrobe & fifoFull & ~popReq;
    end

    // Pointer, occupancy and overflow next-state; a new overflow outranks
    // a simultaneous clear so no drop can go unreported.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pushAccept) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (popReq) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({pushAccept, popReq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (pushDrop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem_q[wrPtr_q] <= {irSel, sr};
        end
    end

    // Head-of-queue view, forced to zero while empty so stale storage is
    // never visible.
    always_comb begin
        headEntry = mem_q[rdPtr_q];
        cmd_valid = (count_q != '0);
        cmd_ir    = '0;
        cmd_data  = '0;
        if (cmd_valid) begin
            cmd_ir   = headEntry[EW-1:DR_W];
            cmd_data = headEntry[DR_W-1:0];
        end
        cmd_count = count_q;
        ovf       = ovf_q;
    end

    // ------------------------------------------------------------------
    // Pop decode
    // ------------------------------------------------------------------
    logic [DR_W-1:0] jdo_q;
    logic [DR_W-1:0] jdo_d;
    logic [NCH-1:0]  takeAction_q;
    logic [NCH-1:0]  takeAction_d;
    logic [NCH-1:0]  takeNoAction_q;
    logic [NCH-1:0]  takeNoAction_d;
    logic [NCH-1:0]  chanSel;

    // On a pop, latch the data for the debug logic and raise exactly one
    // pulse bit chosen by the instruction and the action bit.
    always_comb begin
        chanSel        = NCH'(1) << cmd_ir;
        jdo_d          = jdo_q;
        takeAction_d   = '0;
        takeNoAction_d = '0;
        if (popReq) begin
            jdo_d = cmd_data;
            if (cmd_data[ACTION_BIT]) begin
                takeAction_d = chanSel;
            end else begin
                takeNoAction_d = chanSel;
            end
        end
    end

    // Decode output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jdo_q          <= '0;
            takeAction_q   <= '0;
            takeNoAction_q <= '0;
        end else begin
            jdo_q          <= jdo_d;
            takeAction_q   <= takeAction_d;
            takeNoAction_q <= takeNoAction_d;
        end
    end

    // Drive the registered decode outputs.
    always_comb begin
        jdo            = jdo_q;
        take_action    = takeAction_q;
        take_no_action = takeNoAction_q;
    end

endmodule
